// File: rtl/spi_pkg.sv
// spi_pkg: constants and types shared by the SPI register controller.
//   spi_state_t  - controller FSM state encoding (also driven on the debug port)
//   CMD_RW_BIT   - command byte bit selecting write (1) or read (0)
//   FILL_BYTE    - byte returned to the master while it writes data
//   STATUS_RST   - message counter value after reset
//   ERR_MAX      - saturation value of the protocol-error counter
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } spi_state_t;

  localparam int          CMD_RW_BIT = 7;
  localparam logic [7:0]  FILL_BYTE  = 8'h00;
  localparam logic [7:0]  STATUS_RST = 8'h00;
  localparam logic [7:0]  ERR_MAX    = 8'hFF;

endpackage

// File: rtl/spi_addr_ctr.sv
// spi_addr_ctr: loadable register-address counter that wraps 2^ADDR_W-1 -> 0.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (counter -> 0)
//   load      - replace the count with load_val
//   load_val  - value used when load is high
//   inc       - add one; combined with load it yields load_val + 1
//   addr      - current count
module spi_addr_ctr #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] base;

  assign base = load ? load_val : addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load || inc) begin
      // Natural modulo-2^ADDR_W overflow provides the wrap.
      addr <= base + {{(ADDR_W-1){1'b0}}, inc};
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns SPI bytes into register-file reads and writes.
// A message is: command byte (bit7 = 1 write / 0 read, low bits = address),
// then data bytes (writes) or dummy bytes (reads), with auto-increment.
//
// Handshake: msg_start, msg_end and rx_valid are single-cycle pulses with no
// back-pressure; rx_data is only meaningful while rx_valid is high. The
// register file sees single-cycle reg_wr_en / reg_rd_en strobes and returns
// reg_rdata exactly one cycle after reg_rd_en.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   msg_start, msg_end - SSEL assert / deassert pulses
//   rx_valid, rx_data  - received byte strobe and value
//   tx_data            - byte shifted out at the next byte boundary
//   reg_addr, reg_wr_en, reg_wdata, reg_rd_en, reg_rdata - register file port
//   busy               - high while not IDLE
//   err_cnt            - saturating count of bytes received outside a message
//   state_dbg          - current FSM state (spi_state_t encoding)
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_start,
  input  logic              msg_end,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic [7:0]        err_cnt,
  output logic [1:0]        state_dbg
);

  spi_state_t        state, state_nx;
  logic [7:0]        msg_cnt;
  logic              rd_wait;      // reg_rdata is valid this cycle for our read
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] addr_cnt;     // next address to access in the burst

  logic wr_fire, rd_fire, ctr_load, ctr_inc, err_fire, fill_tx, use_cmd_addr;

  assign cmd_addr  = rx_data[ADDR_W-1:0];
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  spi_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (cmd_addr),
    .inc      (ctr_inc),
    .addr     (addr_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    wr_fire      = 1'b0;
    rd_fire      = 1'b0;
    ctr_load     = 1'b0;
    ctr_inc      = 1'b0;
    err_fire     = 1'b0;
    fill_tx      = 1'b0;
    use_cmd_addr = 1'b0;
    if (msg_start) begin
      // A new message wins over everything; a coincident byte is dropped.
      state_nx = ST_CMD;
    end else begin
      if (rx_valid) begin
        unique case (state)
          ST_IDLE: err_fire = 1'b1;
          ST_CMD: begin
            ctr_load = 1'b1;
            if (rx_data[CMD_RW_BIT]) begin
              state_nx = ST_WRITE;
              fill_tx  = 1'b1;
            end else begin
              // Read the command address now; the next dummy byte reads +1.
              state_nx     = ST_READ;
              rd_fire      = 1'b1;
              ctr_inc      = 1'b1;
              use_cmd_addr = 1'b1;
            end
          end
          ST_WRITE: begin
            wr_fire = 1'b1;
            ctr_inc = 1'b1;
          end
          ST_READ: begin
            rd_fire = 1'b1;
            ctr_inc = 1'b1;
          end
          default: state_nx = ST_IDLE;
        endcase
      end
      // A byte arriving with msg_end is still processed above.
      if (msg_end) begin
        state_nx = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data   <= FILL_BYTE;
      reg_addr  <= '0;
      reg_wr_en <= 1'b0;
      reg_wdata <= 8'h00;
      reg_rd_en <= 1'b0;
      rd_wait   <= 1'b0;
      err_cnt   <= 8'h00;
      msg_cnt   <= STATUS_RST;
    end else begin
      reg_wr_en <= wr_fire;
      reg_rd_en <= rd_fire;
      // A read still in flight when a new message starts is discarded;
      // one in flight across msg_end is allowed to land.
      rd_wait   <= reg_rd_en & ~msg_start;
      if (wr_fire || rd_fire) begin
        reg_addr <= use_cmd_addr ? cmd_addr : addr_cnt;
      end
      if (wr_fire) begin
        reg_wdata <= rx_data;
      end
      if (msg_start) begin
        tx_data <= msg_cnt;
        msg_cnt <= msg_cnt + 8'd1;
      end else if (rd_wait) begin
        tx_data <= reg_rdata;
      end else if (fill_tx) begin
        tx_data <= FILL_BYTE;
      end
      if (err_fire && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;
  import spi_pkg::*;

  localparam int ADDR_W = 7;
  localparam int NREG   = 128;
  localparam int M_IDLE = 0, M_CMD = 1, M_WRITE = 2, M_READ = 3;

  logic              clk = 1'b0;
  logic              rst, msg_start, msg_end, rx_valid;
  logic [7:0]        rx_data, tx_data, reg_wdata, reg_rdata, err_cnt;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr_en, reg_rd_en, busy;
  logic [1:0]        state_dbg;

  // clock / reset block
  always #5 clk = ~clk;

  spi_reg_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .msg_start(msg_start), .msg_end(msg_end),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_data(tx_data),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata),
    .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy),
    .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  // register file: registered read, preload port used during reset
  logic [7:0]        mem [NREG];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr;
  logic [7:0]        pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (reg_wr_en) mem[reg_addr] <= reg_wdata;
    if (reg_rd_en) reg_rdata <= mem[reg_addr];
  end

  // reference model state (message-level view)
  logic [7:0] model_mem [NREG];
  int         m_mode, m_addr, m_msg, m_err;
  logic [7:0] m_tx;

  // scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [14:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every write must match the next expected one; strobes never overlap
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("wr_rd_excl", {31'b0, reg_wr_en & reg_rd_en}, 32'd0);
      if (reg_wr_en) begin
        check("wr_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("wr_log", {reg_addr, reg_wdata}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic start_msg(input bit with_rx, input logic [7:0] b);
    msg_start = 1'b1; rx_valid = with_rx; rx_data = b;
    @(negedge clk);
    msg_start = 1'b0; rx_valid = 1'b0;
    m_tx   = m_msg[7:0];
    m_msg  = (m_msg + 1) % 256;
    m_mode = M_CMD;
    check("status", tx_data, m_tx);
    check("busy_start", busy, 1);
    check("state_cmd", state_dbg, ST_CMD);
    check("err_keep", err_cnt, m_err);
  endtask

  task automatic end_msg();
    msg_end = 1'b1;
    @(negedge clk);
    msg_end = 1'b0;
    m_mode = M_IDLE;
    check("busy_end", busy, 0);
    check("state_idle", state_dbg, ST_IDLE);
    check("tx_end", tx_data, m_tx);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_end);
    bit                exp_wr = 1'b0;
    bit                exp_rd = 1'b0;
    logic [ADDR_W-1:0] exp_a  = '0;
    logic [7:0]        old_tx = m_tx;
    case (m_mode)
      M_IDLE: if (m_err < 255) m_err++;
      M_CMD: begin
        if (b[7]) begin
          m_mode = M_WRITE; m_addr = int'(b[6:0]); m_tx = 8'h00;
        end else begin
          m_mode = M_READ; exp_rd = 1'b1; exp_a = b[6:0];
          m_addr = (int'(b[6:0]) + 1) % NREG;
        end
      end
      M_WRITE: begin
        exp_wr = 1'b1; exp_a = m_addr[ADDR_W-1:0];
        model_mem[m_addr] = b;
        exp_q.push_back({exp_a, b});
        m_addr = (m_addr + 1) % NREG;
      end
      default: begin
        exp_rd = 1'b1; exp_a = m_addr[ADDR_W-1:0];
        m_addr = (m_addr + 1) % NREG;
      end
    endcase
    if (with_end) m_mode = M_IDLE;
    rx_data = b; rx_valid = 1'b1; msg_end = with_end;
    @(negedge clk);
    rx_valid = 1'b0; msg_end = 1'b0;
    check("wr_en", reg_wr_en, exp_wr);
    check("rd_en", reg_rd_en, exp_rd);
    if (exp_wr || exp_rd) check("addr", reg_addr, exp_a);
    if (exp_wr) check("wdata", reg_wdata, b);
    check("busy", busy, m_mode != M_IDLE);
    check("err_cnt", err_cnt, m_err);
    if (exp_rd) begin
      @(negedge clk);
      check("tx_hold", tx_data, old_tx);
      m_tx = model_mem[exp_a];
      @(negedge clk);
      check("tx_read", tx_data, m_tx);
    end else begin
      check("tx", tx_data, m_tx);
    end
  endtask

  initial begin
    rst = 1'b1; msg_start = 1'b0; msg_end = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    m_mode = M_IDLE; m_addr = 0; m_msg = 0; m_err = 0; m_tx = 8'h00;

    // preload register file while in reset
    for (int i = 0; i < NREG; i++) begin
      logic [7:0] v;
      v = (i == 3) ? 8'hAB : (i == 4) ? 8'hCD : 8'($urandom_range(0, 255));
      model_mem[i] = v;
      pl_en = 1'b1; pl_addr = 7'(i); pl_data = v;
      @(negedge clk);
    end
    pl_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", tx_data, 8'h00);
    check("rst_addr", reg_addr, 0);
    check("rst_wr", reg_wr_en, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_rd", reg_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_cnt, 0);
    check("rst_state", state_dbg, ST_IDLE);

    // write burst, read burst, wrap; status 0,1,2
    start_msg(1'b0, 8'h00);
    send_byte(8'h85, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    end_msg();
    start_msg(1'b0, 8'h00);
    send_byte(8'h03, 1'b0); check("rd_burst0", tx_data, 8'hAB);
    send_byte(8'h00, 1'b0); check("rd_burst1", tx_data, 8'hCD);
    send_byte(8'h00, 1'b0);
    end_msg();
    start_msg(1'b0, 8'h00);
    send_byte(8'hFF, 1'b0); send_byte(8'h5A, 1'b0); send_byte(8'hA5, 1'b0);
    end_msg();
    check("wrap_127", model_mem[127], 8'h5A);

    // byte together with msg_end, and a read finishing after msg_end
    start_msg(1'b0, 8'h00);
    send_byte(8'h90, 1'b0); send_byte(8'h3C, 1'b1);
    start_msg(1'b0, 8'h00);
    send_byte(8'h10, 1'b1);
    check("late_read", tx_data, 8'h3C);

    // msg_start with rx_valid: from IDLE and aborting a write
    start_msg(1'b1, 8'h85);
    send_byte(8'hC0, 1'b0); send_byte(8'h77, 1'b0);
    start_msg(1'b1, 8'h99);
    end_msg();

    // pending read discarded by msg_start
    start_msg(1'b0, 8'h00);
    rx_data = 8'h03; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("pend_rd_en", reg_rd_en, 1);
    start_msg(1'b0, 8'h00);
    @(negedge clk);
    check("pend_discard", tx_data, m_tx);
    end_msg();

    // randomized messages
    for (int k = 0; k < 30; k++) begin
      int n;
      bit ended, e;
      start_msg(1'b0, 8'h00);
      n = $urandom_range(0, 4);
      e = (n == 0) && ($urandom_range(0, 1) == 1);
      ended = e;
      send_byte(8'($urandom_range(0, 255)), e);
      for (int j = 0; j < n; j++) begin
        e = (j == n - 1) && ($urandom_range(0, 3) == 0);
        send_byte(8'($urandom_range(0, 255)), e);
        ended |= e;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (!ended && $urandom_range(0, 4) != 0) end_msg();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    end_msg();

    // bytes outside a message: counted, saturating, no strobes
    for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    check("err_sat", err_cnt, 8'hFF);
    start_msg(1'b1, 8'h01);
    end_msg();

    // reset mid-read after the read strobe
    start_msg(1'b0, 8'h00);
    rx_data = 8'h05; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("mid_rd_en", reg_rd_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_mode = M_IDLE; m_msg = 0; m_err = 0; m_tx = 8'h00;
    check("mid_rst_tx", tx_data, 8'h00);
    check("mid_rst_state", state_dbg, ST_IDLE);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err_cnt, 0);
    check("mid_rst_addr", reg_addr, 0);
    @(negedge clk);
    check("mid_rst_no_upd", tx_data, 8'h00);
    start_msg(1'b0, 8'h00);
    end_msg();

    repeat (4) @(negedge clk);
    check("wr_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
